// File: rtl/cpu4_ifetch.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Keeps the PC, issues one instruction-memory request at a time over a
// req/ack handshake, and hands fetched words to decode. A one-entry skid
// buffer catches a word that returns while decode is stalled. Redirects
// that arrive while a request is outstanding are parked until that
// request's ack, because the request has to stay stable until then.
module cpu4_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        pc_redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);

    // Fetch controller states.
    localparam logic [1:0] S_IDLE = 2'd0;  // one-cycle gap after reset
    localparam logic [1:0] S_REQ  = 2'd1;  // live request at pc_reg
    localparam logic [1:0] S_KILL = 2'd2;  // waiting out a request whose data is dead
    localparam logic [1:0] S_SKID = 2'd3;  // skid buffer full, no request

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] tgt_reg, tgt_next;

    logic [31:0] instr_d_reg, instr_d_next;
    logic [31:0] pc_d_reg, pc_d_next;
    logic [31:0] pcplus4_d_reg, pcplus4_d_next;
    logic        valid_d_reg, valid_d_next;

    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic        skid_valid_reg, skid_valid_next;

    logic [31:0] redirect_aligned;
    logic [31:0] pc_inc;
    logic [31:0] skid_pc_inc;
    logic        accept;
    logic        consume;

    // Targets are word addresses; the low bits of a redirect are dropped.
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
    assign pc_inc      = pc_reg + 32'd4;
    assign skid_pc_inc = skid_pc_reg + 32'd4;

    // IF/ID can take a new word if it is empty or its word leaves this cycle.
    assign accept  = !valid_d_reg || !stall_d;
    assign consume = valid_d_reg && !stall_d;

    // The request is held in S_KILL too: the memory must see it to completion.
    assign imem_req  = (state_reg == S_REQ) || (state_reg == S_KILL);
    assign imem_addr = pc_reg;

    assign instr_d   = instr_d_reg;
    assign pc_d      = pc_d_reg;
    assign pcplus4_d = pcplus4_d_reg;
    assign valid_d   = valid_d_reg;

    // Next-state logic: redirect beats ack, ack beats stall/consume.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        tgt_next        = tgt_reg;
        instr_d_next    = instr_d_reg;
        pc_d_next       = pc_d_reg;
        pcplus4_d_next  = pcplus4_d_reg;
        valid_d_next    = valid_d_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        skid_valid_next = skid_valid_reg;

        case (state_reg)
            S_IDLE: begin
                // Any ack seen here belongs to a request cut off by reset.
                state_next = S_REQ;
            end

            S_REQ: begin
                if (pc_redirect) begin
                    valid_d_next = 1'b0;
                    if (imem_ack) begin
                        // Request finishes now, so the target can go out next.
                        pc_next = redirect_aligned;
                    end else begin
                        // Address must stay put until ack; park the target.
                        tgt_next   = redirect_aligned;
                        state_next = S_KILL;
                    end
                end else if (imem_ack) begin
                    pc_next = pc_inc;
                    if (accept) begin
                        instr_d_next   = imem_rdata;
                        pc_d_next      = pc_reg;
                        pcplus4_d_next = pc_inc;
                        valid_d_next   = 1'b1;
                    end else begin
                        skid_instr_next = imem_rdata;
                        skid_pc_next    = pc_reg;
                        skid_valid_next = 1'b1;
                        state_next      = S_SKID;
                    end
                end else if (consume) begin
                    valid_d_next = 1'b0;
                end
            end

            S_KILL: begin
                valid_d_next = 1'b0;
                if (imem_ack) begin
                    // Dead data is dropped; the newest redirect wins.
                    pc_next    = pc_redirect ? redirect_aligned : tgt_reg;
                    state_next = S_REQ;
                end else if (pc_redirect) begin
                    tgt_next = redirect_aligned;
                end
            end

            S_SKID: begin
                if (pc_redirect) begin
                    skid_valid_next = 1'b0;
                    valid_d_next    = 1'b0;
                    pc_next         = redirect_aligned;
                    state_next      = S_REQ;
                end else if (!stall_d) begin
                    instr_d_next    = skid_instr_reg;
                    pc_d_next       = skid_pc_reg;
                    pcplus4_d_next  = skid_pc_inc;
                    valid_d_next    = 1'b1;
                    skid_valid_next = 1'b0;
                    state_next      = S_REQ;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and pipeline registers; reset takes effect immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            tgt_reg        <= 32'd0;
            instr_d_reg    <= 32'd0;
            pc_d_reg       <= 32'd0;
            pcplus4_d_reg  <= 32'd0;
            valid_d_reg    <= 1'b0;
            skid_instr_reg <= 32'd0;
            skid_pc_reg    <= 32'd0;
            skid_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            tgt_reg        <= tgt_next;
            instr_d_reg    <= instr_d_next;
            pc_d_reg       <= pc_d_next;
            pcplus4_d_reg  <= pcplus4_d_next;
            valid_d_reg    <= valid_d_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

endmodule

// File: tb/tb_cpu4_ifetch.sv
// Directed bench for cpu4_ifetch. Two instances: the default one at
// RESET_PC=0 and one at 32'hFFFF_FFFC for wrap and mid-request reset.
// Each instance has a small memory model acking after a programmable
// number of request cycles (1 = ack in the same cycle as req).
module tb_cpu4_ifetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory contents: address 0 holds 8C010004, every other word is
    // 2000_xxxx with xxxx the low half of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h8C01_0004 : {16'h2000, a[15:0]};
    endfunction

    // ---------------- main instance ----------------
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_d = 1'b0;
    logic        pc_redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] instr_d, pc_d, pcplus4_d;
    logic        valid_d;
    int          lat = 1;
    int          cnt = 0;

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = imem_req && (cnt + 1 >= lat);
    always @(posedge clk) cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;

    cpu4_ifetch u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall_d(stall_d), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d)
    );

    // ---------------- wrap instance ----------------
    logic        reset_w = 1'b1;
    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_ack_w;
    logic [31:0] imem_rdata_w;
    logic        stall_d_w = 1'b0;
    logic        pc_redirect_w = 1'b0;
    logic [31:0] redirect_pc_w = 32'd0;
    logic [31:0] instr_d_w, pc_d_w, pcplus4_d_w;
    logic        valid_d_w;
    logic        ack_force_w = 1'b0;
    int          lat_w = 1;
    int          cnt_w = 0;

    assign imem_rdata_w = mem_word(imem_addr_w);
    assign imem_ack_w   = ack_force_w | (imem_req_w && (cnt_w + 1 >= lat_w));
    always @(posedge clk) cnt_w <= (imem_req_w && !imem_ack_w) ? cnt_w + 1 : 0;

    cpu4_ifetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_w (
        .clk(clk), .reset(reset_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .stall_d(stall_d_w), .pc_redirect(pc_redirect_w), .redirect_pc(redirect_pc_w),
        .instr_d(instr_d_w), .pc_d(pc_d_w), .pcplus4_d(pcplus4_d_w), .valid_d(valid_d_w)
    );

    // One rising edge, then settle at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        $display("test_reset: req=%0b valid=%0b instr=%h pc_d=%h pc4=%h addr=%h",
                 imem_req, valid_d, instr_d, pc_d, pcplus4_d, imem_addr);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_d); end
        checks++; if (instr_d !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr_d); end
        checks++; if (pc_d !== 32'd0) begin errors++; $display("FAIL reset_pc_d: got %h want 0", pc_d); end
        checks++; if (pcplus4_d !== 32'd0) begin errors++; $display("FAIL reset_pc4: got %h want 0", pcplus4_d); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_first_fetch();
        lat = 1;
        reset = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL first_idle_req: got %b want 0", imem_req); end
        tick();
        $display("first_fetch e1: req=%0b addr=%h valid=%0b", imem_req, imem_addr, valid_d);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL first_addr: got %h want 0", imem_addr); end
        checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL first_valid0: got %b want 0", valid_d); end
        tick();
        $display("first_fetch e2: valid=%0b instr=%h pc_d=%h pc4=%h addr=%h", valid_d, instr_d, pc_d, pcplus4_d, imem_addr);
        checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", valid_d); end
        checks++; if (instr_d !== 32'h8C01_0004) begin errors++; $display("FAIL first_instr: got %h want 8c010004", instr_d); end
        checks++; if (pc_d !== 32'd0) begin errors++; $display("FAIL first_pc_d: got %h want 0", pc_d); end
        checks++; if (pcplus4_d !== 32'd4) begin errors++; $display("FAIL first_pc4: got %h want 4", pcplus4_d); end
        checks++; if (imem_addr !== 32'd4) begin errors++; $display("FAIL first_next_addr: got %h want 4", imem_addr); end
        // Back-to-back: one instruction per cycle with same-cycle ack.
        tick();
        $display("back_to_back: valid=%0b instr=%h pc_d=%h", valid_d, instr_d, pc_d);
        checks++; if (valid_d !== 1'b1 || pc_d !== 32'd4 || instr_d !== 32'h2000_0004) begin
            errors++; $display("FAIL b2b_1: got v=%b pc=%h i=%h want v=1 pc=4 i=20000004", valid_d, pc_d, instr_d); end
        tick();
        $display("back_to_back: valid=%0b instr=%h pc_d=%h", valid_d, instr_d, pc_d);
        checks++; if (valid_d !== 1'b1 || pc_d !== 32'd8 || instr_d !== 32'h2000_0008) begin
            errors++; $display("FAIL b2b_2: got v=%b pc=%h i=%h want v=1 pc=8 i=20000008", valid_d, pc_d, instr_d); end
    endtask

    task automatic test_latency();
        logic [31:0] exp_addr  [10] = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd4, 32'd4, 32'd8, 32'd8, 32'd8, 32'd12};
        logic        exp_valid [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_pc    [10] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd8};
        lat = 3;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            $display("latency e%0d: addr=%h valid=%0b pc_d=%h", k + 1, imem_addr, valid_d, pc_d);
            checks++; if (imem_addr !== exp_addr[k] || valid_d !== exp_valid[k]) begin
                errors++; $display("FAIL latency_e%0d: got addr=%h v=%b want addr=%h v=%b", k + 1, imem_addr, valid_d, exp_addr[k], exp_valid[k]); end
            if (exp_valid[k]) begin
                checks++; if (pc_d !== exp_pc[k]) begin errors++; $display("FAIL latency_pc_e%0d: got %h want %h", k + 1, pc_d, exp_pc[k]); end
            end
        end
    endtask

    task automatic test_stall_skid();
        lat = 1;
        do_reset();
        tick();            // e1: request at 0
        stall_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();        // e2 loads IF/ID, e3 fills skid, e4/e5 hold
            $display("stall e%0d: req=%0b valid=%0b instr=%h pc_d=%h", k + 2, imem_req, valid_d, instr_d, pc_d);
            checks++; if (valid_d !== 1'b1 || instr_d !== 32'h8C01_0004 || pc_d !== 32'd0) begin
                errors++; $display("FAIL stall_hold_e%0d: got v=%b i=%h pc=%h want v=1 i=8c010004 pc=0", k + 2, valid_d, instr_d, pc_d); end
            if (k > 0) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_req_e%0d: got %b want 0", k + 2, imem_req); end
            end
        end
        stall_d = 1'b0;
        tick();            // e6: skid word moves into IF/ID
        $display("skid drain: valid=%0b instr=%h pc_d=%h pc4=%h addr=%h req=%0b", valid_d, instr_d, pc_d, pcplus4_d, imem_addr, imem_req);
        checks++; if (valid_d !== 1'b1 || instr_d !== 32'h2000_0004 || pc_d !== 32'd4 || pcplus4_d !== 32'd8) begin
            errors++; $display("FAIL skid_drain: got v=%b i=%h pc=%h pc4=%h want v=1 i=20000004 pc=4 pc4=8", valid_d, instr_d, pc_d, pcplus4_d); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin
            errors++; $display("FAIL skid_resume: got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr); end
        tick();
        $display("skid resume: valid=%0b instr=%h pc_d=%h", valid_d, instr_d, pc_d);
        checks++; if (valid_d !== 1'b1 || pc_d !== 32'd8 || instr_d !== 32'h2000_0008) begin
            errors++; $display("FAIL skid_next: got v=%b pc=%h i=%h want v=1 pc=8 i=20000008", valid_d, pc_d, instr_d); end
    endtask

    task automatic test_redirect_wait();
        lat = 1;
        do_reset();
        tick(); tick(); tick();   // e3: pc_d=4, request at 8
        lat = 4;
        pc_redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        for (int k = 0; k < 3; k++) begin
            tick();               // e4..e6: killed request at 8 still held
            pc_redirect = 1'b0;
            $display("redirect_wait e%0d: req=%0b addr=%h valid=%0b", k + 4, imem_req, imem_addr, valid_d);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd8 || valid_d !== 1'b0) begin
                errors++; $display("FAIL kill_hold_e%0d: got req=%b addr=%h v=%b want req=1 addr=8 v=0", k + 4, imem_req, imem_addr, valid_d); end
        end
        tick();                   // e7: ack at e6 cycle retires the dead request
        lat = 1;
        $display("redirect_wait e7: addr=%h valid=%0b", imem_addr, valid_d);
        checks++; if (imem_addr !== 32'h0000_0100 || valid_d !== 1'b0) begin
            errors++; $display("FAIL kill_target: got addr=%h v=%b want addr=00000100 v=0", imem_addr, valid_d); end
        tick();
        $display("redirect_wait e8: valid=%0b instr=%h pc_d=%h", valid_d, instr_d, pc_d);
        checks++; if (valid_d !== 1'b1 || pc_d !== 32'h0000_0100 || instr_d !== 32'h2000_0100) begin
            errors++; $display("FAIL kill_first: got v=%b pc=%h i=%h want v=1 pc=100 i=20000100", valid_d, pc_d, instr_d); end
    endtask

    task automatic test_redirect_with_ack();
        // Continues from test_redirect_wait: request at 0x104 acks this cycle.
        pc_redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        pc_redirect = 1'b0;
        $display("redirect_ack: valid=%0b addr=%h", valid_d, imem_addr);
        checks++; if (valid_d !== 1'b0 || imem_addr !== 32'h0000_0200) begin
            errors++; $display("FAIL redir_ack: got v=%b addr=%h want v=0 addr=00000200", valid_d, imem_addr); end
        tick();
        $display("redirect_ack next: valid=%0b instr=%h pc_d=%h pc4=%h", valid_d, instr_d, pc_d, pcplus4_d);
        checks++; if (valid_d !== 1'b1 || pc_d !== 32'h0000_0200 || instr_d !== 32'h2000_0200 || pcplus4_d !== 32'h0000_0204) begin
            errors++; $display("FAIL redir_ack_next: got v=%b pc=%h i=%h pc4=%h want v=1 pc=200 i=20000200 pc4=204", valid_d, pc_d, instr_d, pcplus4_d); end
    endtask

    task automatic test_wrap_and_reset();
        lat_w = 1;
        reset_w = 1'b0;
        tick();                                   // e1: request at FFFFFFFC
        checks++; if (imem_req_w !== 1'b1 || imem_addr_w !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first_req: got req=%b addr=%h want req=1 addr=fffffffc", imem_req_w, imem_addr_w); end
        tick();                                   // e2
        $display("wrap e2: valid=%0b pc_d=%h pc4=%h addr=%h", valid_d_w, pc_d_w, pcplus4_d_w, imem_addr_w);
        checks++; if (valid_d_w !== 1'b1 || pc_d_w !== 32'hFFFF_FFFC || pcplus4_d_w !== 32'd0 || imem_addr_w !== 32'd0) begin
            errors++; $display("FAIL wrap: got v=%b pc=%h pc4=%h addr=%h want v=1 pc=fffffffc pc4=0 addr=0", valid_d_w, pc_d_w, pcplus4_d_w, imem_addr_w); end
        tick();                                   // e3
        $display("wrap e3: pc_d=%h instr=%h", pc_d_w, instr_d_w);
        checks++; if (pc_d_w !== 32'd0 || instr_d_w !== 32'h8C01_0004 || pcplus4_d_w !== 32'd4) begin
            errors++; $display("FAIL wrap_next: got pc=%h i=%h pc4=%h want pc=0 i=8c010004 pc4=4", pc_d_w, instr_d_w, pcplus4_d_w); end
        lat_w = 5;
        pc_redirect_w = 1'b1;
        redirect_pc_w = 32'h0000_0040;
        tick();                                   // e4: into the kill state
        pc_redirect_w = 1'b0;
        checks++; if (imem_req_w !== 1'b1 || imem_addr_w !== 32'd4 || valid_d_w !== 1'b0) begin
            errors++; $display("FAIL wrap_kill: got req=%b addr=%h v=%b want req=1 addr=4 v=0", imem_req_w, imem_addr_w, valid_d_w); end
        #2 reset_w = 1'b1;                        // asynchronous, between edges
        #1;
        $display("mid_kill reset: req=%0b valid=%0b instr=%h pc_d=%h pc4=%h addr=%h",
                 imem_req_w, valid_d_w, instr_d_w, pc_d_w, pcplus4_d_w, imem_addr_w);
        checks++; if (imem_req_w !== 1'b0 || valid_d_w !== 1'b0 || instr_d_w !== 32'd0 || pc_d_w !== 32'd0 ||
                      pcplus4_d_w !== 32'd0 || imem_addr_w !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL async_reset: got req=%b v=%b i=%h pc=%h pc4=%h addr=%h want all clear addr=fffffffc",
                               imem_req_w, valid_d_w, instr_d_w, pc_d_w, pcplus4_d_w, imem_addr_w); end
        @(negedge clk);
        tick();
        reset_w = 1'b0;
        lat_w = 1;
        ack_force_w = 1'b1;                       // stray ack while idle
        tick();                                   // e1 after release
        ack_force_w = 1'b0;
        $display("post_reset e1: req=%0b addr=%h valid=%0b", imem_req_w, imem_addr_w, valid_d_w);
        checks++; if (imem_req_w !== 1'b1 || imem_addr_w !== 32'hFFFF_FFFC || valid_d_w !== 1'b0) begin
            errors++; $display("FAIL post_reset_req: got req=%b addr=%h v=%b want req=1 addr=fffffffc v=0", imem_req_w, imem_addr_w, valid_d_w); end
        tick();
        $display("post_reset e2: valid=%0b pc_d=%h instr=%h", valid_d_w, pc_d_w, instr_d_w);
        checks++; if (valid_d_w !== 1'b1 || pc_d_w !== 32'hFFFF_FFFC || instr_d_w !== 32'h2000_FFFC) begin
            errors++; $display("FAIL post_reset_fetch: got v=%b pc=%h i=%h want v=1 pc=fffffffc i=2000fffc", valid_d_w, pc_d_w, instr_d_w); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_latency();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_with_ack();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
